// File: rtl/combat_pkg.sv
// Shared combat definitions: player state codes, hit flag codes,
// box field offsets within the 120-bit packing and resolver FSM encoding.
package combat_pkg;

  typedef enum logic [3:0] {
    S_IDLE              = 4'd0,
    S_MOVEFORWARDS      = 4'd1,
    S_MOVEBACKWARDS     = 4'd2,
    S_B_ATTACK_START    = 4'd3,
    S_B_ATTACK_END      = 4'd4,
    S_B_ATTACK_RECOVERY = 4'd5,
    S_D_ATTACK_START    = 4'd6,
    S_D_ATTACK_END      = 4'd7,
    S_D_ATTACK_RECOVERY = 4'd8,
    S_HITSTUN           = 4'd9,
    S_BLOCKSTUN         = 4'd10
  } player_state_t;

  typedef enum logic [1:0] {
    NOT_HIT   = 2'b00,
    HIT_BASIC = 2'b01,
    HIT_DIR   = 2'b10
  } hit_t;

  typedef enum logic [1:0] {
    ST_FIGHT = 2'd0,
    ST_KO    = 2'd1,
    ST_OVER  = 2'd2
  } resolver_state_t;

  // Box packing: {basic, dir, hurt}, each box {x1, x2, y1, y2}, 10 bits per field
  localparam int COORD_W   = 10;
  localparam int BOX_W     = 4 * COORD_W;
  localparam int BASIC_OFS = 2 * BOX_W;
  localparam int DIR_OFS   = BOX_W;
  localparam int HURT_OFS  = 0;
  localparam int X1_OFS    = 3 * COORD_W;
  localparam int X2_OFS    = 2 * COORD_W;
  localparam int Y1_OFS    = COORD_W;
  localparam int Y2_OFS    = 0;

  localparam logic [2:0] HEALTH_INIT  = 3'd5;
  localparam logic [2:0] BLOCK_INIT   = 3'd3;
  localparam logic [2:0] DMG_BASIC    = 3'd1;
  localparam logic [2:0] DMG_DIR      = 3'd2;
  localparam logic [5:0] KO_HOLD      = 6'd40;
  localparam logic [7:0] REGEN_FRAMES = 8'd120;

  typedef struct packed {
    logic [2:0] health;
    logic [2:0] block;
    logic       blocked;
  } defense_t;

  // Outcome for a defender this frame: a backwards-walking defender with charges
  // spends one, otherwise health drops by the attack damage, clamped at zero.
  function automatic defense_t resolve_defense(input logic [2:0] health,
                                               input logic [2:0] block,
                                               input logic [3:0] def_state,
                                               input logic       hit,
                                               input hit_t       kind);
    defense_t   r;
    logic [2:0] dmg;
    r.health  = health;
    r.block   = block;
    r.blocked = 1'b0;
    dmg = (kind == HIT_DIR) ? DMG_DIR : DMG_BASIC;
    if (hit) begin
      if (def_state == S_MOVEBACKWARDS && block != 3'd0) begin
        r.block   = block - 3'd1;
        r.blocked = 1'b1;
      end else begin
        r.health = (health > dmg) ? (health - dmg) : 3'd0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Inclusive axis-aligned rectangle intersection between an attack box and a hurt box.
module box_overlap
  import combat_pkg::*;
(
  input  logic [BOX_W-1:0] atk_box,
  input  logic [BOX_W-1:0] hurt_box,
  output logic             overlap
);

  logic [COORD_W-1:0] ax1, ax2, ay1, ay2;
  logic [COORD_W-1:0] bx1, bx2, by1, by2;

  assign ax1 = atk_box[X1_OFS +: COORD_W];
  assign ax2 = atk_box[X2_OFS +: COORD_W];
  assign ay1 = atk_box[Y1_OFS +: COORD_W];
  assign ay2 = atk_box[Y2_OFS +: COORD_W];
  assign bx1 = hurt_box[X1_OFS +: COORD_W];
  assign bx2 = hurt_box[X2_OFS +: COORD_W];
  assign by1 = hurt_box[Y1_OFS +: COORD_W];
  assign by2 = hurt_box[Y2_OFS +: COORD_W];

  assign overlap = (ax1 <= bx2) && (bx1 <= ax2) && (ay1 <= by2) && (by1 <= ay2);

endmodule

// File: rtl/hit_resolver.sv
// Combat judge: detects connecting attacks between two players each frame,
// applies damage or block, and runs the KO / round-over sequence.
// Optional feature macro: BLOCK_REGEN_EN (periodic block charge recharge).
module hit_resolver
  import combat_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         round_start,
  input  logic [3:0]   p1_state,
  input  logic [3:0]   p2_state,
  input  logic [119:0] p1_boxes,
  input  logic [119:0] p2_boxes,
  output logic [1:0]   p1_hitFlag,
  output logic [1:0]   p2_hitFlag,
  output logic [2:0]   p1_health,
  output logic [2:0]   p2_health,
  output logic [2:0]   p1_block,
  output logic [2:0]   p2_block,
  output logic         game_over,
  output logic [1:0]   winner
);

  resolver_state_t state, state_nxt;

  logic             p1_swing, p2_swing;
  hit_t             p1_kind, p2_kind;
  logic [BOX_W-1:0] p1_atk_box, p2_atk_box;
  logic             p1_overlap, p2_overlap;
  logic             p1_vuln, p2_vuln;
  logic             p1_hits, p2_hits;
  logic             p1_hit_done, p2_hit_done;
  defense_t         p1_def, p2_def;
  logic [2:0]       p1_block_fight, p2_block_fight;
  hit_t             p1_flag_q, p2_flag_q;
  logic [5:0]       ko_cnt;

  // Attackers in an active frame pick their basic or directional box
  assign p1_swing   = (p1_state == S_B_ATTACK_END) || (p1_state == S_D_ATTACK_END);
  assign p2_swing   = (p2_state == S_B_ATTACK_END) || (p2_state == S_D_ATTACK_END);
  assign p1_kind    = (p1_state == S_D_ATTACK_END) ? HIT_DIR : HIT_BASIC;
  assign p2_kind    = (p2_state == S_D_ATTACK_END) ? HIT_DIR : HIT_BASIC;
  assign p1_atk_box = (p1_state == S_D_ATTACK_END) ? p1_boxes[DIR_OFS +: BOX_W]
                                                   : p1_boxes[BASIC_OFS +: BOX_W];
  assign p2_atk_box = (p2_state == S_D_ATTACK_END) ? p2_boxes[DIR_OFS +: BOX_W]
                                                   : p2_boxes[BASIC_OFS +: BOX_W];

  box_overlap u_p1_on_p2 (
    .atk_box  (p1_atk_box),
    .hurt_box (p2_boxes[HURT_OFS +: BOX_W]),
    .overlap  (p1_overlap)
  );

  box_overlap u_p2_on_p1 (
    .atk_box  (p2_atk_box),
    .hurt_box (p1_boxes[HURT_OFS +: BOX_W]),
    .overlap  (p2_overlap)
  );

  // A defender already reeling from a hit or block cannot be hit again
  assign p1_vuln = !((p1_state == S_HITSTUN) || (p1_state == S_BLOCKSTUN));
  assign p2_vuln = !((p2_state == S_HITSTUN) || (p2_state == S_BLOCKSTUN));

  assign p1_hits = (state == ST_FIGHT) && p1_swing && p1_overlap && p2_vuln && !p1_hit_done;
  assign p2_hits = (state == ST_FIGHT) && p2_swing && p2_overlap && p1_vuln && !p2_hit_done;

  // p1_def is player 1 as defender (hit by player 2) and vice versa
  assign p1_def = resolve_defense(p1_health, p1_block, p1_state, p2_hits, p2_kind);
  assign p2_def = resolve_defense(p2_health, p2_block, p2_state, p1_hits, p1_kind);

`ifdef BLOCK_REGEN_EN
  logic [7:0] p1_regen_cnt, p2_regen_cnt;
  logic       p1_regen_tick, p2_regen_tick;
  logic       p1_regen_hold, p2_regen_hold;

  assign p1_regen_hold = p1_def.blocked || (p1_state == S_BLOCKSTUN);
  assign p2_regen_hold = p2_def.blocked || (p2_state == S_BLOCKSTUN);
  assign p1_regen_tick = (p1_regen_cnt == REGEN_FRAMES - 8'd1) && !p1_regen_hold;
  assign p2_regen_tick = (p2_regen_cnt == REGEN_FRAMES - 8'd1) && !p2_regen_hold;

  assign p1_block_fight = (p1_regen_tick && p1_block < BLOCK_INIT) ? p1_block + 3'd1
                                                                   : p1_def.block;
  assign p2_block_fight = (p2_regen_tick && p2_block < BLOCK_INIT) ? p2_block + 3'd1
                                                                   : p2_def.block;

  // Recharge timers run only while fighting and restart on any block activity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_regen_cnt <= 8'd0;
      p2_regen_cnt <= 8'd0;
    end else if (state == ST_OVER && round_start) begin
      p1_regen_cnt <= 8'd0;
      p2_regen_cnt <= 8'd0;
    end else if (state == ST_FIGHT) begin
      p1_regen_cnt <= (p1_regen_hold || p1_regen_tick) ? 8'd0 : p1_regen_cnt + 8'd1;
      p2_regen_cnt <= (p2_regen_hold || p2_regen_tick) ? 8'd0 : p2_regen_cnt + 8'd1;
    end
  end
`else
  assign p1_block_fight = p1_def.block;
  assign p2_block_fight = p2_def.block;
`endif

  // Round state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_FIGHT;
    else     state <= state_nxt;
  end

  // Round sequencing: fight until a KO, hold, then wait for a new round
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FIGHT: if (p1_def.health == 3'd0 || p2_def.health == 3'd0) state_nxt = ST_KO;
      ST_KO:    if (ko_cnt == KO_HOLD - 6'd1) state_nxt = ST_OVER;
      ST_OVER:  if (round_start) state_nxt = ST_FIGHT;
      default:  state_nxt = ST_FIGHT;
    endcase
  end

  // Hit latches, flags, health/block, KO timer and winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_hit_done <= 1'b0;
      p2_hit_done <= 1'b0;
      p1_flag_q   <= NOT_HIT;
      p2_flag_q   <= NOT_HIT;
      p1_health   <= HEALTH_INIT;
      p2_health   <= HEALTH_INIT;
      p1_block    <= BLOCK_INIT;
      p2_block    <= BLOCK_INIT;
      ko_cnt      <= 6'd0;
      winner      <= 2'b00;
    end else begin
      if (state == ST_OVER && round_start) p1_hit_done <= 1'b0;
      else if (p1_hits)                    p1_hit_done <= 1'b1;
      else if (!p1_swing)                  p1_hit_done <= 1'b0;

      if (state == ST_OVER && round_start) p2_hit_done <= 1'b0;
      else if (p2_hits)                    p2_hit_done <= 1'b1;
      else if (!p2_swing)                  p2_hit_done <= 1'b0;

      p1_flag_q <= NOT_HIT;
      p2_flag_q <= NOT_HIT;

      case (state)
        ST_FIGHT: begin
          if (p2_hits) p1_flag_q <= p2_kind;
          if (p1_hits) p2_flag_q <= p1_kind;
          p1_health <= p1_def.health;
          p2_health <= p2_def.health;
          p1_block  <= p1_block_fight;
          p2_block  <= p2_block_fight;
          ko_cnt    <= 6'd0;
          if (state_nxt == ST_KO)
            winner <= {p1_def.health == 3'd0, p2_def.health == 3'd0};
        end
        ST_KO: begin
          ko_cnt <= ko_cnt + 6'd1;
        end
        ST_OVER: begin
          if (round_start) begin
            p1_health <= HEALTH_INIT;
            p2_health <= HEALTH_INIT;
            p1_block  <= BLOCK_INIT;
            p2_block  <= BLOCK_INIT;
            winner    <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

  assign p1_hitFlag = p1_flag_q;
  assign p2_hitFlag = p2_flag_q;
  assign game_over  = (state == ST_KO) || (state == ST_OVER);

endmodule
